spi_rom_master: RTL and testbench
=================================

SPI_ROM_MASTER -- requirements
Module: spi_rom_master

Interface
REQ-001 Parameter: CLK_DIV, default 8, i_clk cycles per SCK half-period (legal 4..255).
REQ-002 Ports: i_clk, input, 1, single clock; all logic on rising edge.
REQ-003 Ports: i_rst, input, 1, synchronous active-high reset.
REQ-004 Ports: i_start, input, 1, one-cycle transaction request, accepted only in IDLE.
REQ-005 Ports: i_addr, input, 8, ROM start address, captured when i_start is accepted.
REQ-006 Ports: i_len, input, 4, data bytes to read (0..15), captured with i_addr.
REQ-007 Ports: i_miso, input, 1, serial data from the slave.
REQ-008 Ports: o_sck, output, 1, SPI clock, idle low.
REQ-009 Ports: o_en_n, output, 1, active-low chip select.
REQ-010 Ports: o_mosi, output, 1, serial address, MSB first.
REQ-011 Ports: o_data, output, 8, last received byte; holds until the next byte.
REQ-012 Ports: o_valid, output, 1, one-cycle pulse when o_data updates.
REQ-013 Ports: o_busy, output, 1, high in every state except IDLE.
REQ-014 Ports: o_done, output, 1, one-cycle pulse on the return to IDLE.

Function
REQ-015 FSM states: IDLE, SETUP, ADDR, TURN, DATA, HOLD, GAP; all outputs registered.
REQ-016 IDLE + i_start: capture i_addr and i_len, drive o_en_n low, enter SETUP on the next cycle.
REQ-017 SETUP: o_en_n low, o_sck low, o_mosi = i_addr[7], lasts CLK_DIV cycles, then ADDR.
REQ-018 ADDR: 8 SCK periods; each period is CLK_DIV cycles low then CLK_DIV cycles high; o_mosi changes only on SCK falling edges; bits sent MSB first.
REQ-019 TURN: o_sck low for 2*CLK_DIV cycles, o_mosi low; then DATA if captured len>0, else HOLD.
REQ-020 DATA: 8*len SCK periods with the same timing as ADDR; i_miso sampled in the last i_clk cycle of each SCK low phase; bits assembled MSB first.
REQ-021 After the 8th bit of a byte: o_data loads it and o_valid pulses on the following cycle; this repeats once per byte.
REQ-022 HOLD: o_sck low, o_en_n low, CLK_DIV cycles, then GAP.
REQ-023 GAP: o_en_n high for CLK_DIV cycles; then IDLE, with o_done pulsing in the first IDLE cycle.
REQ-024 Timing: o_en_n low time = CLK_DIV*(1+16+2+16*len+1) cycles exactly.
REQ-025 i_start while o_busy=1 is ignored; it has no effect on the captured address or length.
REQ-026 The counters (half-period, bit, byte) do not wrap mid-transaction; the byte counter terminates at the captured len.

Reset
REQ-027 i_rst=1 at any clock edge, including mid-transaction: next state IDLE; o_sck=0, o_en_n=1, o_mosi=0, o_data=8'h00, o_valid=0, o_busy=0, o_done=0; all counters cleared.
REQ-028 An aborted transaction produces no o_valid and no o_done pulse.

Configuration
REQ-029 Macro SPI_MISO_SYNC_EN: when defined, i_miso passes through a 2-flop synchronizer before sampling, and the sample point stays as in REQ-020 using the synchronized value; CLK_DIV >= 8 is required.
REQ-030 Without SPI_MISO_SYNC_EN: i_miso is sampled directly at the REQ-020 point, and CLK_DIV >= 4 is required.

Verification
REQ-031 Reset idle: CLK_DIV=4, i_rst high for 3 cycles -> o_en_n=1, o_sck=0, o_busy=0, o_data=8'h00.
REQ-032 Single read: CLK_DIV=4, i_addr=8'h41, i_len=1, slave model returns 8'h5A -> MOSI bits 0100_0001; one o_valid with o_data=8'h5A; o_en_n low 144 cycles; one o_done.
REQ-033 Burst read: i_len=3, slave returns 8'h10, 8'h11, 8'h12 -> 3 o_valid pulses, in order, each 16*CLK_DIV cycles apart.
REQ-034 Address only: i_len=0 -> 8 SCK rising edges total; no o_valid; o_en_n low 80 cycles at CLK_DIV=4.
REQ-035 Busy ignore and abort: i_start during DATA -> ignored; i_rst during byte 2 of a 3-byte read -> IDLE next cycle, no further o_valid, no o_done.

Source files
------------

// File: rtl/spi_rom_master.sv
// SPI ROM read master: sends an 8-bit address, then reads i_len bytes MSB first.
// Define SPI_MISO_SYNC_EN to put a 2-flop synchronizer on i_miso (requires CLK_DIV >= 8).
module spi_rom_master #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_addr,
    input  logic [3:0] i_len,
    input  logic       i_miso,
    output logic       o_sck,
    output logic       o_en_n,
    output logic       o_mosi,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_done
);

    typedef enum logic [2:0] {IDLE, SETUP, ADDR, TURN, DATA, HOLD, GAP} state_t;

    localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
    localparam logic [8:0] TURN_LAST = 9'(2 * CLK_DIV - 1);

    state_t     state, state_d;
    logic [8:0] div_cnt, div_cnt_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [3:0] byte_cnt, byte_cnt_d;
    logic [3:0] len_r, len_d;
    logic [7:0] addr_sh, addr_sh_d;
    logic [7:0] rx_sh, rx_sh_d;
    logic [7:0] rx_byte;
    logic [7:0] data_d;
    logic       sck_d, en_n_d, mosi_d, valid_d, busy_d, done_d;
    logic       half_end;
    logic       miso_s;

`ifdef SPI_MISO_SYNC_EN
    logic [1:0] miso_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) miso_sync <= '0;
        else       miso_sync <= {miso_sync[0], i_miso};
    end

    assign miso_s = miso_sync[1];
`else
    assign miso_s = i_miso;
`endif

    assign half_end = (div_cnt == HALF_LAST);
    assign rx_byte  = {rx_sh[6:0], miso_s};

    always_comb begin
        state_d    = state;
        div_cnt_d  = div_cnt + 9'd1;
        bit_cnt_d  = bit_cnt;
        byte_cnt_d = byte_cnt;
        len_d      = len_r;
        addr_sh_d  = addr_sh;
        rx_sh_d    = rx_sh;
        sck_d      = o_sck;
        en_n_d     = o_en_n;
        mosi_d     = o_mosi;
        data_d     = o_data;
        valid_d    = 1'b0;
        busy_d     = 1'b1;
        done_d     = 1'b0;

        case (state)
            IDLE: begin
                div_cnt_d = '0;
                busy_d    = 1'b0;
                sck_d     = 1'b0;
                en_n_d    = 1'b1;
                mosi_d    = 1'b0;
                if (i_start) begin
                    state_d    = SETUP;
                    len_d      = i_len;
                    addr_sh_d  = i_addr;
                    en_n_d     = 1'b0;
                    mosi_d     = i_addr[7];
                    busy_d     = 1'b1;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                end
            end
            SETUP: begin
                if (half_end) begin
                    state_d   = ADDR;
                    div_cnt_d = '0;
                end
            end
            ADDR, DATA: begin
                if (half_end) begin
                    div_cnt_d = '0;
                    if (!o_sck) begin
                        // End of low phase: rising SCK, and the MISO sample point
                        sck_d = 1'b1;
                        if (state == DATA) begin
                            rx_sh_d = rx_byte;
                            if (bit_cnt == 3'd7) begin
                                data_d  = rx_byte;
                                valid_d = 1'b1;
                            end
                        end
                    end else begin
                        sck_d = 1'b0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt_d = '0;
                            if (state == ADDR) begin
                                state_d = TURN;
                                mosi_d  = 1'b0;
                            end else if (byte_cnt + 4'd1 == len_r) begin
                                state_d = HOLD;
                            end else begin
                                byte_cnt_d = byte_cnt + 4'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt + 3'd1;
                            if (state == ADDR) begin
                                addr_sh_d = {addr_sh[6:0], 1'b0};
                                mosi_d    = addr_sh[6];
                            end
                        end
                    end
                end
            end
            TURN: begin
                if (div_cnt == TURN_LAST) begin
                    div_cnt_d = '0;
                    state_d   = (len_r != 4'd0) ? DATA : HOLD;
                end
            end
            HOLD: begin
                if (half_end) begin
                    div_cnt_d = '0;
                    state_d   = GAP;
                    en_n_d    = 1'b1;
                end
            end
            GAP: begin
                if (half_end) begin
                    div_cnt_d = '0;
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len_r    <= '0;
            addr_sh  <= '0;
            rx_sh    <= '0;
            o_sck    <= 1'b0;
            o_en_n   <= 1'b1;
            o_mosi   <= 1'b0;
            o_data   <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            state    <= state_d;
            div_cnt  <= div_cnt_d;
            bit_cnt  <= bit_cnt_d;
            byte_cnt <= byte_cnt_d;
            len_r    <= len_d;
            addr_sh  <= addr_sh_d;
            rx_sh    <= rx_sh_d;
            o_sck    <= sck_d;
            o_en_n   <= en_n_d;
            o_mosi   <= mosi_d;
            o_data   <= data_d;
            o_valid  <= valid_d;
            o_busy   <= busy_d;
            o_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_spi_rom_master.sv
// Scoreboard bench for spi_rom_master: SPI ROM slave model, expected-response queues
// and a monitor that checks read bytes, chip-select timing, address bits and done pulses.
module tb_spi_rom_master;

    localparam int unsigned CDIV  = 4;
    localparam int unsigned LIMIT = CDIV * (20 + 16 * 15) + 100;

    typedef struct {
        int unsigned en_len;
        int unsigned rises;
        logic [7:0]  addr;
        logic        aborted;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] addr = '0;
    logic [3:0] len = '0;
    logic       miso = 1'b0;
    logic       sck, en_n, mosi, valid, busy, done;
    logic [7:0] data;

    int unsigned errors = 0;
    int unsigned checks = 0;
    int unsigned cyc = 0;
    int unsigned exp_done = 0;
    int unsigned done_seen = 0;

    logic [7:0] slave_bytes [16];
    logic [7:0] exp_q [$];
    txn_t       txn_q [$];

    spi_rom_master #(.CLK_DIV(CDIV)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start),
        .i_addr (addr),
        .i_len  (len),
        .i_miso (miso),
        .o_sck  (sck),
        .o_en_n (en_n),
        .o_mosi (mosi),
        .o_data (data),
        .o_valid(valid),
        .o_busy (busy),
        .o_done (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // ROM slave: captures the address on SCK rises, shifts data out after SCK falls
    int unsigned rise_cnt = 0;
    logic [7:0]  cap_addr = '0;
    logic        s_prev_sck = 1'b0;
    logic        s_prev_en = 1'b1;

    always @(negedge clk) begin
        int unsigned k;
        if (s_prev_en && !en_n) begin
            rise_cnt = 0;
            cap_addr = '0;
        end
        if (!s_prev_sck && sck) begin
            if (rise_cnt < 8) cap_addr = {cap_addr[6:0], mosi};
            rise_cnt++;
        end
        if (s_prev_sck && !sck && rise_cnt >= 8) begin
            k    = rise_cnt - 8;
            miso = slave_bytes[k / 8][7 - (k % 8)];
        end
        s_prev_sck = sck;
        s_prev_en  = en_n;
    end

    // Monitor: pops expectations whenever the DUT presents a result
    int unsigned en_low = 0;
    int unsigned nvalid_txn = 0;
    int unsigned last_valid = 0;
    logic        m_prev_en = 1'b1;

    always @(negedge clk) begin
        txn_t t;
        if (m_prev_en && !en_n) nvalid_txn = 0;
        if (!en_n) en_low++;
        if (!m_prev_en && en_n) begin
            if (txn_q.size() == 0) begin
                check("unexpected_cs_rise", 1, 0);
            end else begin
                t = txn_q.pop_front();
                if (!t.aborted) begin
                    check("en_n_low_cycles", en_low, t.en_len);
                    check("sck_rises", rise_cnt, t.rises);
                    check("mosi_addr", cap_addr, t.addr);
                end
            end
            en_low = 0;
        end
        if (valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("rx_data", data, exp_q.pop_front());
            end
            if (nvalid_txn > 0) check("valid_spacing", cyc - last_valid, 16 * CDIV);
            nvalid_txn++;
            last_valid = cyc;
        end
        if (done) done_seen++;
        m_prev_en = en_n;
    end

    task automatic wait_done();
        int unsigned n = 0;
        while (!done && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", done, 1);
        @(negedge clk);
    endtask

    task automatic pulse_start(input logic [7:0] a, input logic [3:0] l);
        @(negedge clk);
        start = 1'b1;
        addr  = a;
        len   = l;
        @(negedge clk);
        start = 1'b0;
        addr  = 8'($urandom);
        len   = 4'($urandom);
    endtask

    // Reference: CS low for CLK_DIV*(20+16*len) cycles, 8+8*len SCK rises, slave bytes in order
    task automatic run_txn(input logic [7:0] a, input int unsigned n, input bit poke_mid);
        int unsigned w = 0;
        txn_t t;
        t.en_len  = CDIV * (20 + 16 * n);
        t.rises   = 8 + 8 * n;
        t.addr    = a;
        t.aborted = 1'b0;
        txn_q.push_back(t);
        for (int i = 0; i < int'(n); i++) exp_q.push_back(slave_bytes[i]);
        exp_done++;
        pulse_start(a, 4'(n));
        if (poke_mid) begin
            while (rise_cnt < 10 && w < LIMIT) begin
                @(negedge clk);
                w++;
            end
            check("busy_during_data", busy, 1);
            start = 1'b1;
            addr  = ~a;
            len   = 4'd15;
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        check("busy_after_done", busy, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) slave_bytes[i] = '0;

        repeat (3) @(negedge clk);
        check("rst_en_n", en_n, 1);
        check("rst_sck", sck, 0);
        check("rst_busy", busy, 0);
        check("rst_data", data, 0);
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        slave_bytes[0] = 8'h5A;
        run_txn(8'h41, 1, 1'b0);

        slave_bytes[0] = 8'h10;
        slave_bytes[1] = 8'h11;
        slave_bytes[2] = 8'h12;
        run_txn(8'($urandom), 3, 1'b1);

        run_txn(8'hC3, 0, 1'b0);

        for (int i = 0; i < 15; i++) slave_bytes[i] = 8'($urandom);
        run_txn(8'hFF, 15, 1'b0);

        begin : abort_case
            txn_t t;
            int unsigned w = 0;
            for (int i = 0; i < 3; i++) slave_bytes[i] = 8'($urandom);
            t.en_len  = 0;
            t.rises   = 0;
            t.addr    = '0;
            t.aborted = 1'b1;
            txn_q.push_back(t);
            exp_q.push_back(slave_bytes[0]);
            pulse_start(8'h5C, 4'd3);
            while (!valid && w < LIMIT) begin
                @(negedge clk);
                w++;
            end
            check("abort_first_valid", valid, 1);
            repeat (8 * CDIV) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("abort_busy", busy, 0);
            check("abort_en_n", en_n, 1);
            check("abort_sck", sck, 0);
            check("abort_mosi", mosi, 0);
            check("abort_data", data, 0);
            check("abort_done", done, 0);
            rst = 1'b0;
            repeat (40 * CDIV) @(negedge clk);
            check("abort_idle_busy", busy, 0);
        end

        for (int r = 0; r < 8; r++) begin
            int unsigned n;
            n = $urandom_range(0, 4);
            for (int i = 0; i < 16; i++) slave_bytes[i] = 8'($urandom);
            run_txn(8'($urandom), n, ($urandom_range(0, 1) == 1) && (n > 0));
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("pending_bytes", exp_q.size(), 0);
        check("pending_txns", txn_q.size(), 0);
        check("done_count", done_seen, exp_done);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
